// File: rtl/obi_timer_responder.sv
// OBI data-bus responder exposing a RISC-V style mtime/mtimecmp timer.
// Single-cycle response after grant; grant may be delayed by GNT_WAIT cycles.
module obi_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1500_0000,
  parameter int unsigned GNT_WAIT  = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        irq_timer_o
);

  localparam logic [2:0] L_WAIT = 3'(GNT_WAIT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [2:0]  r_wait_cnt;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [1:0]  r_ctrl;
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic        w_gnt;
  logic [31:0] w_off;
  logic        w_hit;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_wr_mlo;
  logic        w_wr_mhi;
  logic        w_wr_clo;
  logic        w_wr_chi;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_tick;
  logic [31:0] w_rd;

  function automatic logic [31:0] f_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign w_gnt = !rst_i && req_i && (r_wait_cnt == L_WAIT);
  assign gnt_o = w_gnt;

  // Offset compare also rejects addresses below the base (wraps large).
  assign w_off = addr_i - BASE_ADDR;
  assign w_hit = (w_off < 32'h18) && (w_off[1:0] == 2'b00);
  assign w_idx = w_off[4:2];

  assign w_wr      = w_gnt && we_i && w_hit;
  assign w_wr_mlo  = w_wr && (w_idx == 3'd0);
  assign w_wr_mhi  = w_wr && (w_idx == 3'd1);
  assign w_wr_clo  = w_wr && (w_idx == 3'd2);
  assign w_wr_chi  = w_wr && (w_idx == 3'd3);
  assign w_wr_ctrl = w_wr && (w_idx == 3'd4);
  assign w_wr_pre  = w_wr && (w_idx == 3'd5);

  assign w_tick = r_ctrl[0] && (r_pcnt == r_prescale);

  always_comb begin
    w_rd = 32'd0;
    if (w_hit) begin
      unique case (w_idx)
        3'd0:    w_rd = r_mtime[31:0];
        3'd1:    w_rd = r_mtime[63:32];
        3'd2:    w_rd = r_mtimecmp[31:0];
        3'd3:    w_rd = r_mtimecmp[63:32];
        3'd4:    w_rd = {30'd0, r_ctrl};
        3'd5:    w_rd = {16'd0, r_prescale};
        default: w_rd = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
    end else if (req_i && !w_gnt) begin
      r_state    <= S_WAIT;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 3'd1 : 3'd1;
    end else begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcnt <= 16'd0;
    end else if (!r_ctrl[0] || w_wr_pre) begin
      r_pcnt <= 16'd0;
    end else if (r_pcnt == r_prescale) begin
      r_pcnt <= 16'd0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  // A bus write to either mtime half suppresses that cycle's increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime <= 64'd0;
    end else if (w_wr_mlo || w_wr_mhi) begin
      if (w_wr_mlo)
        r_mtime[31:0] <= f_merge(r_mtime[31:0], wdata_i, be_i);
      if (w_wr_mhi)
        r_mtime[63:32] <= f_merge(r_mtime[63:32], wdata_i, be_i);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_ctrl     <= 2'd0;
      r_prescale <= 16'd0;
    end else begin
      if (w_wr_clo)
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], wdata_i, be_i);
      if (w_wr_chi)
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], wdata_i, be_i);
      if (w_wr_ctrl && be_i[0])
        r_ctrl <= wdata_i[1:0];
      if (w_wr_pre) begin
        if (be_i[0]) r_prescale[7:0]  <= wdata_i[7:0];
        if (be_i[1]) r_prescale[15:8] <= wdata_i[15:8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= (w_gnt && !we_i) ? w_rd : 32'd0;
      r_irq    <= r_ctrl[1] && (r_mtime >= r_mtimecmp);
    end
  end

  // Masking by rst_i cancels a response already registered when reset hits.
  assign rvalid_o    = r_rvalid && !rst_i;
  assign rdata_o     = rst_i ? 32'd0 : r_rdata;
  assign irq_timer_o = r_irq && !rst_i;

endmodule

// File: tb/tb_obi_timer_responder.sv
// Randomized and directed bench for obi_timer_responder.
// Expected values come from a register-array model and timer arithmetic.
module tb_obi_timer_responder;

  localparam logic [31:0] BASE = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a;
  logic        req_b;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt_a, rvalid_a, irq_a;
  logic [31:0] rdata_a;
  logic        gnt_b, rvalid_b, irq_b;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic [31:0] m [6];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  obi_timer_responder #(.BASE_ADDR(BASE), .GNT_WAIT(0)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(gnt_a),
    .rvalid_o(rvalid_a), .rdata_o(rdata_a), .irq_timer_o(irq_a)
  );

  obi_timer_responder #(.BASE_ADDR(BASE), .GNT_WAIT(3)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(gnt_b),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b), .irq_timer_o(irq_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] bmerge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] b
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m[0] = 32'd0; m[1] = 32'd0;
    m[2] = 32'hFFFF_FFFF; m[3] = 32'hFFFF_FFFF;
    m[4] = 32'd0; m[5] = 32'd0;
  endtask

  task automatic model_write(input logic [31:0] off, input logic [3:0] b,
                             input logic [31:0] d);
    if (off < 32'h18 && off[1:0] == 2'b00) begin
      m[off[4:2]] = bmerge(m[off[4:2]], d, b);
      m[4] = m[4] & 32'h3;
      m[5] = m[5] & 32'hFFFF;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One transaction on DUT A; returns read data and the acceptance edge.
  task automatic bus_a(input logic w, input logic [31:0] off,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output int acc);
    int n;
    n = 0;
    req_a = 1'b1; we = w; addr = BASE + off; be = b; wdata = d;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++;
      $display("FAIL gnt_same_cycle off=%h got=%b exp=1", off, gnt_a);
    end
    while (gnt_a !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (gnt_a !== 1'b1) begin
      req_a = 1'b0; rd = 32'd0; acc = edges;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    acc = edges;
    req_a = 1'b0; we = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_a !== 1'b1) begin
      errors++;
      $display("FAIL rvalid_after_acc off=%h got=%b exp=1", off, rvalid_a);
    end
    rd = rdata_a;
    @(posedge clk); #1;
    checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'd0) begin
      errors++;
      $display("FAIL rvalid_one_cycle got=%b/%h exp=0/0", rvalid_a, rdata_a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int acc;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    we = 1'b0; addr = BASE + 32'h8; be = 4'hF; wdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt_a, gnt_b, rvalid_a, rdata_a, irq_a} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b %h %b exp=0",
               gnt_a, gnt_b, rvalid_a, rdata_a, irq_a);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus_a(1'b0, 32'(i * 4), 4'hF, 32'd0, rd, acc);
      checks++;
      if (rd !== m[i]) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, rd, m[i]);
      end
    end
  endtask

  task automatic test_rw();
    logic [31:0] rd;
    int acc;
    bus_a(1'b1, 32'h8, 4'hF, 32'h1234_5678, rd, acc);
    model_write(32'h8, 4'hF, 32'h1234_5678);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL write_rdata got=%h exp=0", rd);
    end
    bus_a(1'b0, 32'h8, 4'hF, 32'd0, rd, acc);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rw_cmp_lo got=%h exp=12345678", rd);
    end
  endtask

  task automatic test_byte_en();
    logic [31:0] rd;
    int acc;
    do_reset();
    bus_a(1'b1, 32'h14, 4'b0001, 32'hAABB_CCDD, rd, acc);
    model_write(32'h14, 4'b0001, 32'hAABB_CCDD);
    bus_a(1'b0, 32'h14, 4'hF, 32'd0, rd, acc);
    checks++;
    if (rd !== 32'h0000_00DD) begin
      errors++;
      $display("FAIL byte_en got=%h exp=000000dd", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] offs [3];
    logic [31:0] exp [3];
    offs = '{32'h8, 32'h14, 32'hC};
    for (int i = 0; i < 3; i++) exp[i] = m[offs[i][4:2]];
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        req_a = 1'b1; we = 1'b0; be = 4'hF; addr = BASE + offs[i];
      end else begin
        req_a = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== exp[i-1]) begin
          errors++;
          $display("FAIL b2b_resp%0d got=%b/%h exp=1/%h",
                   i - 1, rvalid_a, rdata_a, exp[i-1]);
        end
      end
      if (i < 3) begin
        checks++;
        if (gnt_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gnt%0d got=%b exp=1", i, gnt_a);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail got=%b exp=0", rvalid_a);
    end
  endtask

  task automatic test_grant_wait();
    req_b = 1'b1; we = 1'b0; be = 4'hF; addr = BASE + 32'hC;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (gnt_b !== (n == 4)) begin
        errors++;
        $display("FAIL gw_gnt cyc%0d got=%b exp=%b", n, gnt_b, n == 4);
      end
    end
    @(posedge clk); #1 req_b = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL gw_resp got=%b/%h exp=1/ffffffff", rvalid_b, rdata_b);
    end
    @(posedge clk); #1 req_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_b = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b0 || rvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL gw_drop got=%b/%b exp=0/0", gnt_b, rvalid_b);
    end
    @(posedge clk); #1 req_b = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (gnt_b !== (n == 4)) begin
        errors++;
        $display("FAIL gw_restart cyc%0d got=%b exp=%b", n, gnt_b, n == 4);
      end
    end
    @(posedge clk); #1 req_b = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_b !== 1'b1) begin
      errors++;
      $display("FAIL gw_restart_resp got=%b exp=1", rvalid_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] offs [12];
    logic [31:0] off, d, rd, exp;
    logic [3:0]  b;
    logic        w, hit, exp_irq;
    int acc;
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14,
             32'h18, 32'h40, 32'h11, 32'h2, 32'h10, 32'h4};
    do_reset();
    for (int k = 0; k < 60; k++) begin
      off = offs[$urandom_range(0, 11)];
      w   = 1'($urandom_range(0, 1));
      b   = 4'($urandom);
      d   = $urandom;
      if (off == 32'h10) d = d & ~32'h1;
      hit = (off < 32'h18) && (off[1:0] == 2'b00);
      exp = (!w && hit) ? m[off[4:2]] : 32'd0;
      bus_a(w, off, b, d, rd, acc);
      if (w) model_write(off, b, d);
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL rand%0d we=%b off=%h got=%h exp=%h", k, w, off, rd, exp);
      end
      exp_irq = m[4][1] && ({m[1], m[0]} >= {m[3], m[2]});
      checks++;
      if (irq_a !== exp_irq) begin
        errors++;
        $display("FAIL rand_irq%0d got=%b exp=%b", k, irq_a, exp_irq);
      end
    end
  endtask

  task automatic test_timer_irq();
    logic [31:0] rd;
    int e0, acc, k;
    logic exp;
    do_reset();
    bus_a(1'b1, 32'h14, 4'hF, 32'd1, rd, acc);
    bus_a(1'b1, 32'h8,  4'hF, 32'd5, rd, acc);
    bus_a(1'b1, 32'hC,  4'hF, 32'd0, rd, acc);
    bus_a(1'b1, 32'h10, 4'hF, 32'd3, rd, e0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      k = edges - e0;
      exp = ((k - 1) / 2) >= 5;
      checks++;
      if (irq_a !== exp) begin
        errors++;
        $display("FAIL irq_edge%0d got=%b exp=%b", k, irq_a, exp);
      end
    end
    @(posedge clk); #1;
    bus_a(1'b0, 32'h0, 4'hF, 32'd0, rd, acc);
    checks++;
    if (rd !== 32'((acc - 1 - e0) / 2)) begin
      errors++;
      $display("FAIL timer_mtime got=%h exp=%h", rd, (acc - 1 - e0) / 2);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [63:0] e;
    int e0, w0, acc;
    do_reset();
    bus_a(1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, rd, acc);
    bus_a(1'b1, 32'h4, 4'hF, 32'hFFFF_FFFF, rd, acc);
    bus_a(1'b1, 32'h10, 4'hF, 32'd1, rd, e0);
    bus_a(1'b0, 32'h0, 4'hF, 32'd0, rd, acc);
    e = 64'hFFFF_FFFF_FFFF_FFFF + 64'(acc - 1 - e0);
    checks++;
    if (rd !== e[31:0]) begin
      errors++;
      $display("FAIL wrap_lo got=%h exp=%h", rd, e[31:0]);
    end
    bus_a(1'b0, 32'h4, 4'hF, 32'd0, rd, acc);
    e = 64'hFFFF_FFFF_FFFF_FFFF + 64'(acc - 1 - e0);
    checks++;
    if (rd !== e[63:32]) begin
      errors++;
      $display("FAIL wrap_hi got=%h exp=%h", rd, e[63:32]);
    end
    bus_a(1'b1, 32'h0, 4'hF, 32'h0000_0100, rd, w0);
    bus_a(1'b0, 32'h0, 4'hF, 32'd0, rd, acc);
    checks++;
    if (rd !== 32'h100 + 32'(acc - 1 - w0)) begin
      errors++;
      $display("FAIL collide_lo got=%h exp=%h", rd, 32'h100 + 32'(acc - 1 - w0));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a = 1'b1; we = 1'b0; be = 4'hF; addr = BASE + 32'h8;
    @(posedge clk); #1;
    rst = 1'b1; req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid_a, rdata_a, gnt_a, irq_a} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b %h %b %b exp=0",
               rvalid_a, rdata_a, gnt_a, irq_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got=%b exp=0", rvalid_a);
    end
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    int acc;
    do_reset();
    bus_a(1'b1, 32'h8, 4'hF, 32'hCAFE_F00D, rd, acc);
    model_write(32'h8, 4'hF, 32'hCAFE_F00D);
    bus_a(1'b1, 32'h40, 4'hF, 32'h5555_AAAA, rd, acc);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_wr got=%h exp=0", rd);
    end
    bus_a(1'b0, 32'h48, 4'hF, 32'd0, rd, acc);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_rd got=%h exp=0", rd);
    end
    bus_a(1'b0, 32'h9, 4'hF, 32'd0, rd, acc);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL misaligned_rd got=%h exp=0", rd);
    end
    for (int i = 0; i < 6; i++) begin
      bus_a(1'b0, 32'(i * 4), 4'hF, 32'd0, rd, acc);
      checks++;
      if (rd !== m[i]) begin
        errors++;
        $display("FAIL unmapped_reg%0d got=%h exp=%h", i, rd, m[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_byte_en();
    test_back_to_back();
    test_grant_wait();
    test_random();
    test_timer_irq();
    test_wrap();
    test_reset_mid();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
